// File: rtl/comp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } result_t;

    // One-hot flag triple ordered {gt, lt, eq}.
    function automatic logic [2:0] flags_of(input result_t r);
        logic [2:0] f;
        case (r)
            RES_GT:  f = 3'b100;
            RES_LT:  f = 3'b010;
            default: f = 3'b001;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bit_comp_cell.sv
// Single-bit compare; invert swaps polarity for the two's-complement sign bit.
module bit_comp_cell (
    input  logic a,
    input  logic b,
    input  logic invert,
    output logic gt,
    output logic lt
);

    // A set bit where the other operand is clear normally means "greater";
    // on a sign bit it means "more negative", so the outputs swap.
    always_comb begin
        gt = invert ? (~a & b) : (a & ~b);
        lt = invert ? (a & ~b) : (~a & b);
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial, MSB-first magnitude comparator with start/busy/done handshake.
module serial_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int            IW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             found_q, found_d;
    result_t          rec_q, rec_d;
    logic [2:0]       flags_q, flags_d;

    logic    bit_a, bit_b, invert;
    logic    cell_gt, cell_lt, diff, first_diff;
    result_t new_res, final_res;

    // Select the bit under test; only the sign bit is compared inverted.
    always_comb begin
        bit_a  = a_q[idx_q];
        bit_b  = b_q[idx_q];
        invert = sm_q && (idx_q == IDX_MSB);
    end

    bit_comp_cell u_cell (
        .a      (bit_a),
        .b      (bit_b),
        .invert (invert),
        .gt     (cell_gt),
        .lt     (cell_lt)
    );

    // Next-state, counter, difference record and result-flag update.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sm_d       = sm_q;
        idx_d      = idx_q;
        found_d    = found_q;
        rec_d      = rec_q;
        flags_d    = flags_q;
        diff       = cell_gt | cell_lt;
        first_diff = diff && !found_q;
        new_res    = cell_gt ? RES_GT : RES_LT;
        final_res  = first_diff ? new_res : rec_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sm_d    = signed_mode;
                    idx_d   = IDX_MSB;
                    found_d = 1'b0;
                    rec_d   = RES_EQ;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Only the most significant difference decides the result.
                if (first_diff) begin
                    found_d = 1'b1;
                    rec_d   = new_res;
                end
                if ((EARLY_EXIT && first_diff) || (idx_q == '0)) begin
                    flags_d = flags_of(final_res);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= '0;
            found_q <= 1'b0;
            rec_q   <= RES_EQ;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            rec_q   <= rec_d;
            flags_q <= flags_d;
        end
    end

    assign busy   = (state_q == SCAN);
    assign done   = (state_q == DONE);
    assign A_gt_B = flags_q[2];
    assign A_lt_B = flags_q[1];
    assign A_eq_B = flags_q[0];

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: one early-exit and one fixed-latency instance.
module tb_serial_mag_comp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_e = 1'b0;
    logic         start_f = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         signed_mode = 1'b0;

    logic busy_e, done_e, gt_e, lt_e, eq_e;
    logic busy_f, done_f, gt_f, lt_f, eq_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst(rst), .start(start_e), .A(A), .B(B),
        .signed_mode(signed_mode), .busy(busy_e), .done(done_e),
        .A_gt_B(gt_e), .A_lt_B(lt_e), .A_eq_B(eq_e)
    );

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .A(A), .B(B),
        .signed_mode(signed_mode), .busy(busy_f), .done(done_f),
        .A_gt_B(gt_f), .A_lt_B(lt_f), .A_eq_B(eq_f)
    );

    function automatic logic busy_of(input int which);
        return (which == 1) ? busy_e : busy_f;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 1) ? done_e : done_f;
    endfunction

    function automatic logic [2:0] flags_now(input int which);
        return (which == 1) ? {gt_e, lt_e, eq_e} : {gt_f, lt_f, eq_f};
    endfunction

    // Reference: ordinary numeric comparison, flags as {gt, lt, eq}.
    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
        logic signed [W-1:0] sa, sb;
        logic gt, lt;
        sa = a;
        sb = b;
        gt = sm ? (sa > sb) : (a > b);
        lt = sm ? (sa < sb) : (a < b);
        return {gt, lt, !(gt || lt)};
    endfunction

    // Reference: SCAN cycles = bits examined down to the highest differing one.
    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit early);
        logic [W-1:0] x;
        int top;
        x   = a ^ b;
        top = -1;
        for (int i = 0; i < W; i++) if (x[i]) top = i;
        if (!early || top < 0) return W;
        return W - top;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and pulse start for one cycle; returns #1 after the accepting edge.
    task automatic kick(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm);
        A = a;
        B = b;
        signed_mode = sm;
        if (which == 1) start_e = 1'b1; else start_f = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        start_f = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Wait for done (bounded), then check latency, busy length, flags and pulse width.
    task automatic wait_result(input int which, input logic [2:0] exp_f, input int exp_lat,
                               input int pre, input string tag);
        int   n;
        int   nb;
        logic got;
        n   = pre;
        nb  = pre + (busy_of(which) ? 1 : 0);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            n++;
            if (done_of(which)) got = 1'b1;
            else if (busy_of(which)) nb++;
        end
        check({tag, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "/latency"}, 32'(n), 32'(exp_lat));
            check({tag, "/busy_cycles"}, 32'(nb), 32'(exp_lat));
            check({tag, "/busy_at_done"}, 32'(busy_of(which)), 32'd0);
            check({tag, "/flags"}, 32'(flags_now(which)), 32'(exp_f));
            @(posedge clk); #1;
            check({tag, "/done_pulse"}, 32'(done_of(which)), 32'd0);
            check({tag, "/flags_after"}, 32'(flags_now(which)), 32'(exp_f));
        end
    endtask

    task automatic run_cmp(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input string tag);
        kick(which, a, b, sm);
        wait_result(which, model_flags(a, b, sm), model_lat(a, b, which == 1), 0, tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [2:0]   held;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/e", 32'({busy_e, done_e, gt_e, lt_e, eq_e}), 32'd0);
        check("rst/f", 32'({busy_f, done_f, gt_f, lt_f, eq_f}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_cmp(1, 8'h80, 8'h7F, 1'b0, "u_80_7f");
        run_cmp(1, 8'h5A, 8'h5A, 1'b0, "u_eq_5a");
        run_cmp(1, 8'h04, 8'h05, 1'b0, "u_04_05");
        run_cmp(1, 8'h80, 8'h01, 1'b1, "s_80_01");
        run_cmp(1, 8'h80, 8'h01, 1'b0, "u_80_01");
        run_cmp(1, 8'hFF, 8'hFE, 1'b1, "s_ff_fe");
        run_cmp(1, 8'h01, 8'hFF, 1'b1, "s_01_ff");
        run_cmp(0, 8'h80, 8'h00, 1'b0, "f_80_00");
        run_cmp(0, 8'h81, 8'h80, 1'b0, "f_81_80");
        run_cmp(0, 8'h80, 8'h01, 1'b1, "f_s_80_01");
        run_cmp(0, 8'h7E, 8'h7E, 1'b1, "f_eq");

        // Start pulsed while busy is ignored
        kick(1, 8'h33, 8'h33, 1'b0);
        @(posedge clk); #1;
        A = 8'h00;
        B = 8'hFF;
        signed_mode = 1'b1;
        start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        wait_result(1, 3'b001, W, 2, "ignore_start");

        // Flags hold across idle cycles
        held = 3'b001;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("hold_flags", 32'({flags_now(1), done_e, busy_e}), 32'({held, 2'b00}));
        end

        // Reset in the middle of a scan
        kick(1, 8'h01, 8'h02, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_pre_rst", 32'(busy_e), 32'd1);
        rst = 1'b1;
        start_e = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_e = 1'b0;
        check("mid_rst", 32'({busy_e, done_e, gt_e, lt_e, eq_e}), 32'd0);
        @(posedge clk); #1;
        check("post_rst_idle", 32'({busy_e, done_e}), 32'd0);
        run_cmp(1, 8'h03, 8'h03, 1'b0, "after_rst_eq");

        // Randomized compares against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            rs = 1'($urandom);
            run_cmp((n % 2 == 0) ? 1 : 0, ra, rb, rs, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
